// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captures device IRQ lines into PEND, masks them, and
// presents the highest-priority (lowest index) eligible source to CP0.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [3:2]      Addr,
  input  logic            WE,
  input  logic [31:0]     DataI,
  output logic [31:0]     DataO,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack,
  output logic [1:0]      state_dbg
);

  // CP0 handshake: int_req stays high with int_id tracking the best eligible source
  // until a one-cycle int_ack pulse accepts it; service ends with a write to EOI.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;

  state_t          state;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] irq_prev;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] pend_next;
  logic [2:0]      sel;
  logic [2:0]      cur;
  logic            busy;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_eoi;
  logic            ack_take;
  logic            unused_data;

  assign rise      = irq_in & ~irq_prev;
  assign eligible  = pend & mask;
  assign wr_pend   = WE && (Addr == 2'd0);
  assign wr_mask   = WE && (Addr == 2'd1);
  assign wr_eoi    = WE && (Addr == 2'd3);
  assign ack_take  = (state == REQ) && int_ack;
  assign state_dbg = state;

  // Data bits above the implemented sources carry no meaning.
  assign unused_data = &{1'b0, DataI[31:NSRC]};

  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  // Clears (software W1C, ack) first, then new edges, so a same-cycle edge wins.
  always_comb begin
    pend_next = pend;
    if (wr_pend) pend_next = pend_next & ~DataI[NSRC-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (ack_take && (int_id == 3'(i))) pend_next[i] = 1'b0;
    end
    pend_next = pend_next | rise;
  end

  always_comb begin
    DataO = '0;
    case (Addr)
      2'd0: DataO[NSRC-1:0] = pend;
      2'd1: DataO[NSRC-1:0] = mask;
      2'd2: begin
        DataO[31]  = busy;
        DataO[2:0] = cur;
      end
      default: DataO = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      mask     <= '0;
      irq_prev <= '0;
      cur      <= '0;
      busy     <= 1'b0;
      int_req  <= 1'b0;
      int_id   <= '0;
    end else begin
      irq_prev <= irq_in;
      pend     <= pend_next;
      if (wr_mask) mask <= DataI[NSRC-1:0];
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= sel;
          end
        end
        REQ: begin
          if (int_ack) begin
            state   <= SERV;
            cur     <= int_id;
            busy    <= 1'b1;
            int_req <= 1'b0;
          end else if (eligible == '0) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            int_id  <= sel;
          end
        end
        SERV: begin
          if (wr_eoi) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: driver feeds directed and random cycles into a reference model,
// pushes the predicted post-edge outputs, and a monitor pops and compares them.
module tb_irq_ctrl;
  localparam int NSRC = 6;
  localparam int W = 38;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [3:2]      Addr;
  logic            WE;
  logic [31:0]     DataI;
  logic [31:0]     DataO;
  logic            int_req;
  logic [2:0]      int_id;
  logic            int_ack;
  logic [1:0]      state_dbg;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .Addr(Addr), .WE(WE),
    .DataI(DataI), .DataO(DataO), .int_req(int_req), .int_id(int_id),
    .int_ack(int_ack), .state_dbg(state_dbg)
  );

  // Expected entry: {int_req, int_id[2:0], phase[1:0], DataO[31:0]}.
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 in service.
  int m_pend[NSRC];
  int m_mask[NSRC];
  int m_prev[NSRC];
  int m_phase, m_req, m_id, m_cur, m_busy;
  logic [NSRC-1:0] cur_irq;

  task automatic model_step(input bit rst, input logic [NSRC-1:0] irq, input int a,
                            input bit we, input logic [31:0] d, input bit ack);
    int nxt[NSRC];
    int sel;
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0;
      end
      m_phase = 0; m_req = 0; m_id = 0; m_cur = 0; m_busy = 0;
      return;
    end
    sel = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i] != 0 && m_mask[i] != 0) sel = i;
    for (int i = 0; i < NSRC; i++) begin
      nxt[i] = m_pend[i];
      if (we && a == 0 && d[i]) nxt[i] = 0;
      if (m_phase == 1 && ack && i == m_id) nxt[i] = 0;
      if (irq[i] && m_prev[i] == 0) nxt[i] = 1;
    end
    case (m_phase)
      0: if (sel >= 0) begin m_phase = 1; m_req = 1; m_id = sel; end
      1: begin
        if (ack) begin m_phase = 2; m_cur = m_id; m_busy = 1; m_req = 0; end
        else if (sel < 0) begin m_phase = 0; m_req = 0; end
        else m_id = sel;
      end
      default: if (we && a == 3) begin m_phase = 0; m_busy = 0; end
    endcase
    if (we && a == 1) for (int i = 0; i < NSRC; i++) m_mask[i] = int'(d[i]);
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = nxt[i];
      m_prev[i] = int'(irq[i]);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = '0;
    if (a == 0) for (int i = 0; i < NSRC; i++) v[i] = (m_pend[i] != 0);
    if (a == 1) for (int i = 0; i < NSRC; i++) v[i] = (m_mask[i] != 0);
    if (a == 2) begin
      v[31] = (m_busy != 0);
      v[2:0] = 3'(m_cur);
    end
    return v;
  endfunction

  task automatic drive(input bit rst, input logic [NSRC-1:0] irq, input logic [1:0] a,
                       input bit we, input logic [31:0] d, input bit ack);
    reset = rst; irq_in = irq; Addr = a; WE = we; DataI = d; int_ack = ack;
    model_step(rst, irq, int'(a), we, d, ack);
    @(posedge clk);
    exp_q.push_back({1'(m_req), 3'(m_id), 2'(m_phase), model_read(int'(a))});
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    drive(1'b0, cur_irq, 2'($urandom_range(0, 3)), 1'b0, $urandom, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b0, cur_irq, a, 1'b1, d, 1'b0);
  endtask

  task automatic ack1();
    drive(1'b0, cur_irq, 2'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("int_req", 32'(int_req), 32'(e[37]));
        check("int_id", 32'(int_id), 32'(e[36:34]));
        check("state", 32'(state_dbg), 32'(e[33:32]));
        check("DataO", DataO, e[31:0]);
      end
    end
  end

  initial begin
    int r;
    bit ack, we, rst;
    logic [1:0] a;
    logic [31:0] d;
    reset = 1'b1; irq_in = '0; Addr = '0; WE = 1'b0; DataI = '0; int_ack = 1'b0;
    cur_irq = '0;
    drive(1'b1, cur_irq, 2'd0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, cur_irq, 2'd2, 1'b0, 32'h0, 1'b0);

    // Single source round trip, including EOI.
    wr(2'd1, 32'h01);
    ticks(1);
    cur_irq = 6'h01; tick(); cur_irq = 6'h00;
    ticks(2); ack1(); ticks(1); wr(2'd3, 32'h0); ticks(2);

    // Two simultaneous edges: lower index first, then the other after EOI.
    wr(2'd1, 32'h3F);
    cur_irq = 6'b001010; ticks(2); ack1(); wr(2'd3, 32'h0);
    ticks(2); ack1(); wr(2'd3, 32'h0); cur_irq = '0; ticks(2);

    // Preemption before ack.
    cur_irq = 6'h10; ticks(2); cur_irq = 6'h14; ticks(2); ack1(); ticks(1);
    wr(2'd3, 32'h0); ticks(2); ack1(); wr(2'd3, 32'h0); cur_irq = '0; ticks(2);

    // Masked source, late unmask, W1C withdraws the request.
    wr(2'd1, 32'h00);
    cur_irq = 6'h01; tick(); cur_irq = '0; ticks(2);
    wr(2'd1, 32'h01); ticks(2); wr(2'd0, 32'h01); ticks(2);

    // Held level captured once; re-edge plus simultaneous W1C keeps the bit set.
    wr(2'd1, 32'h3F);
    cur_irq = 6'h20; ticks(3); ack1(); ticks(3); wr(2'd3, 32'h0); ticks(3);
    cur_irq = '0; tick(); wr(2'd1, 32'h00);
    cur_irq = 6'h20; drive(1'b0, cur_irq, 2'd0, 1'b1, 32'h20, 1'b0); ticks(2);
    wr(2'd0, 32'h3F); cur_irq = '0; ticks(1);

    // Reset while in service with pending bits, lines held high across it.
    wr(2'd1, 32'h3F);
    cur_irq = 6'h01; ticks(2); ack1(); cur_irq = 6'h06; ticks(2);
    drive(1'b1, cur_irq, 2'd0, 1'b0, 32'h0, 1'b0);
    ticks(3); wr(2'd1, 32'h3F); ticks(3);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) cur_irq ^= NSRC'(1 << $urandom_range(0, NSRC - 1));
      r = $urandom_range(0, 99);
      rst = (r == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      we = ($urandom_range(0, 9) == 0);
      if (m_phase == 2 && $urandom_range(0, 4) == 0) begin we = 1'b1; a = 2'd3; end
      if (we && a == 2'd1 && $urandom_range(0, 1) == 0) d = 32'h3F;
      ack = (m_req != 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 29) == 0);
      drive(rst, cur_irq, a, we, d, ack);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller between the memory-mapped peripherals (timers and other IRQ sources) and CP0. It edge-captures up to NSRC device IRQ lines into a pending register and applies a software mask. It arbitrates pending sources by fixed priority and presents one request/ID to CP0 with an ack/end-of-interrupt handshake. Software configures it through the system bridge with the same register-port style the timers use (Addr[3:2], WE, DataI, DataO).

Parameters:
NSRC, 6, number of IRQ source lines (1..8); bit i = device i, lower index = higher priority

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
irq_in  in  NSRC  device IRQ lines (level, e.g. timer IRQ)
Addr  in  2 ([3:2])  register select: 0 PEND, 1 MASK, 2 CUR, 3 EOI
WE  in  1  register write enable
DataI  in  32  write data
DataO  out  32  read data, combinational from Addr
int_req  out  1  interrupt request to CP0 (registered)
int_id  out  3  index of requested/served source (registered)
int_ack  in  1  CP0 accepts request (one-cycle pulse, exception entry)

Behaviour:
- Reset (synchronous, active-high, clock clk): PEND=0, MASK=0, irq_prev=0, CUR=0, state=IDLE, int_req=0, int_id=0. Reset overrides every write and event in the same cycle.
- Edge capture: irq_prev<=irq_in each cycle. Rising edge (irq_in[i]=1 and irq_prev[i]=0) at edge k sets PEND[i] at edge k. A line already high when reset deasserts gives an edge on the first cycle after reset.
- PEND write (Addr=0, WE): write-1-to-clear on bits [NSRC-1:0]. A set and a clear of the same bit in one cycle: set wins.
- MASK write (Addr=1): MASK<=DataI[NSRC-1:0]. 1 = enabled.
- CUR (Addr=2) is read-only. Writes are ignored.
- EOI (Addr=3) is write-only. Any write to it is the end-of-interrupt event.
- Reads: Addr0 -> {0,PEND}, Addr1 -> {0,MASK}, Addr2 -> {busy bit31, 0, CUR[2:0]}, Addr3 -> 0. Upper bits are zero-extended.
- eligible = PEND & MASK. sel = lowest set index of eligible.
- FSM states:
  - IDLE: int_req=0. If eligible!=0, go to REQ, set int_req<=1, int_id<=sel.
  - REQ: int_req=1. int_id is updated every cycle to the current sel, so a higher-priority arrival preempts before ack.
    - If eligible becomes 0 (clear or mask) before int_ack: go to IDLE, int_req<=0. The request drops the next cycle.
    - If int_ack: go to SERV, CUR<=int_id, busy<=1, int_req<=0, clear PEND[int_id] in the same edge. Clear beats a simultaneous new edge on that bit only if the edge occurred before this cycle. A new edge in the ack cycle still sets the bit.
  - SERV: int_req=0. New edges still set PEND. No nesting: no request is issued while in SERV.
    - On an EOI write: busy<=0, go to IDLE. If eligible!=0, IDLE re-requests on the next edge.
- int_ack outside REQ is ignored.
- Latency: irq_in rising edge sampled at edge k -> PEND set after k -> int_req high after edge k+1, provided it is masked in and the FSM is IDLE.
- Reset mid-operation (REQ or SERV) returns the block to IDLE with everything cleared. Sources must re-edge to be captured again.
- Bits of PEND and MASK above NSRC do not exist and read as 0.

Test Plan:
- Reset, MASK=0x01, pulse irq_in[0] high at edge 5 -> PEND=0x01 after edge 5, int_req=1 and int_id=0 after edge 6. int_ack at edge 8 -> int_req=0, CUR=0, busy=1, PEND=0x00. EOI write -> busy=0, IDLE.
- MASK=0x3F, raise irq_in[3] and irq_in[1] in the same cycle -> int_id=1. Ack and EOI -> int_id=3 requested on the next edge after EOI.
- MASK=0x3F, irq_in[4] requested (int_id=4). irq_in[2] rises before ack -> int_id changes to 2. Ack -> CUR=2, PEND=0x10.
- MASK=0x00, irq_in[0] edge -> PEND=0x01, int_req stays 0. Write MASK=0x01 -> int_req=1. Write PEND=0x01 (W1C) before ack -> int_req=0, state IDLE.
- irq_in[5] held high: PEND bit set once. Cleared by ack. No re-set while the level is held; a low then high transition sets it again. A set and a W1C in the same cycle leave PEND[5]=1.
- Assert reset while in SERV with PEND=0x06 -> PEND=0, MASK=0, busy=0, int_req=0 next cycle. A line held high afterwards re-captures one cycle after reset deasserts.
